// File: rtl/bus_timer_pkg.sv
// Shared constants for the memory-mapped countdown timer: register indices,
// CTRL field positions, MODE encodings and the FSM state encoding.
package bus_timer_pkg;

    localparam logic [1:0] IDX_CTRL   = 2'd0;
    localparam logic [1:0] IDX_PRESET = 2'd1;
    localparam logic [1:0] IDX_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

endpackage

// File: rtl/bus_timer.sv
// Countdown timer on the CPU data bus. Decodes a 16-byte window at BASE_ADDR,
// exposes CTRL/PRESET/COUNT and raises a sticky, maskable level interrupt.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic        we,
    output logic [31:0] dout,
    output logic        irq
);

    logic        sel;
    logic [1:0]  idx;
    logic        wr_ctrl;
    logic        wr_preset;
    logic [3:0]  ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        irq_flag;
    logic        reload;
    logic        unused_addr_bits;
    state_t      state;
    state_t      state_nxt;

    assign sel              = (addr[31:4] == BASE_ADDR[31:4]);
    assign idx              = addr[3:2];
    assign wr_ctrl          = we && sel && (idx == IDX_CTRL);
    assign wr_preset        = we && sel && (idx == IDX_PRESET);
    assign reload           = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
    assign unused_addr_bits = &addr[1:0];
    assign irq              = irq_flag & ctrl_q[CTRL_IM];

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a COUNT of 0 or 1 both end the countdown so PRESET=0 acts as 1
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (ctrl_q[CTRL_EN]) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_CNT;
            ST_CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_nxt = ST_IDLE;
                end else if (count_q <= 32'd1) begin
                    state_nxt = ST_INT;
                end
            end
            ST_INT:  state_nxt = reload ? ST_LOAD : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // COUNT is loaded in LOAD, decremented in CNT while enabled, and never wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            case (state)
                ST_LOAD: count_q <= preset_q;
                ST_CNT: begin
                    if (ctrl_q[CTRL_EN]) begin
                        count_q <= (count_q > 32'd1) ? (count_q - 32'd1) : 32'd0;
                    end
                end
                default: count_q <= count_q;
            endcase
        end
    end

    // CTRL: a CPU write takes priority over the one-shot auto-clear of EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= '0;
        end else if (wr_ctrl) begin
            ctrl_q <= din[3:0];
        end else if ((state == ST_INT) && !reload) begin
            ctrl_q[CTRL_EN] <= 1'b0;
        end
    end

    // PRESET only changes on CPU writes; COUNT picks it up at the next LOAD
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            preset_q <= '0;
        end else if (wr_preset) begin
            preset_q <= din;
        end
    end

    // Sticky interrupt flag; setting beats a simultaneous CPU clear so no event is lost
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_flag <= 1'b0;
        end else if (state == ST_INT) begin
            irq_flag <= 1'b1;
        end else if (wr_ctrl || wr_preset) begin
            irq_flag <= 1'b0;
        end
    end

    // Combinational read mux; anything outside the window or at index 3 reads 0
    always_comb begin
        dout = '0;
        if (sel) begin
            case (idx)
                IDX_CTRL:   dout = {28'd0, ctrl_q};
                IDX_PRESET: dout = preset_q;
                IDX_COUNT:  dout = count_q;
                default:    dout = '0;
            endcase
        end
    end

endmodule
